rw_stage: RTL and testbench
===========================

Name: rw_stage

Overview:
- Register-write (writeback) stage, directly downstream of the MA/RW pipeline latch.
- Consumes the latched PC, load result, instruction, ALU result and 22-bit control word, and selects the writeback value.
- Owns the 16x32 architectural register file; exposes two read ports to operand fetch.
- Also provides a retired-instruction counter and halt detection.

Parameters:
- NUM_REGS, 16, number of architectural registers (address width fixed at 4)
- RA_INDEX, 15, destination register forced for call instructions
- HALT_OPCODE, 5'b11111, value of inst[31:27] that halts the core

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_MA  in  1  latch holds a real instruction (0 = bubble)
- pc_MA_out  in  32  PC of the retiring instruction
- ldResult  in  32  load data from MA
- inst_out_ma  in  32  instruction word
- alu_res_MA  in  32  ALU result
- control_MA  in  22  control word: bit1 isLd, bit6 isWb, bit8 isCall; other bits ignored
- rs1_addr  in  4  read port 1 address
- rs2_addr  in  4  read port 2 address
- rs1_data  out  32  read port 1 data (combinational)
- rs2_data  out  32  read port 2 data (combinational)
- wb_en  out  1  combinational: write occurs this cycle
- wb_addr  out  4  combinational: destination register
- wb_data  out  32  combinational: value being written
- retired  out  32  count of retired instructions
- halted  out  1  sticky halt flag

Behaviour:
- Reset (async, rst=1): all NUM_REGS registers, retired and halted clear to 0 immediately. State goes to RUN.
- The RF is not written while rst=1, including when reset is asserted mid-cycle.
- inst_out_ma may be X after reset; every use of it is gated by valid_MA.
- Data select, in priority order:
  - isCall: pc_MA_out + 4, 32-bit wrap (0xFFFFFFFC -> 0x00000000)
  - else isLd: ldResult
  - else: alu_res_MA
- Destination: isCall ? RA_INDEX : inst_out_ma[25:22].
- wb_en = valid_MA & isWb & (state==RUN) & ~is_halt, where is_halt = valid_MA & (inst_out_ma[31:27]==HALT_OPCODE).
- The RF write takes effect at the rising clk edge when wb_en=1. Latency: visible on the read ports the cycle after, or the same cycle with bypass (see Optional Feature).
- Every register, including r0, is writable.
- Read ports: rs*_data = RF[rs*_addr], asynchronous.
- State machine, 2 states:
  - RUN -> HALTED on a valid halt instruction.
  - HALTED is absorbing until reset.
  - In HALTED, wb_en=0 and retired is frozen.
  - The halt instruction itself counts as retired and never writes the RF, even if isWb=1.
- retired increments by 1 on each valid_MA=1 cycle in RUN, whether or not it writes. It wraps 0xFFFFFFFF -> 0.
- Bubbles (valid_MA=0) change nothing.
- Back-to-back writes to the same register: the last one wins. There is no per-cycle limit.

Optional Feature:
- Macro: RW_BYPASS_EN.
- Defined: when wb_en=1 and rs*_addr==wb_addr, rs*_data returns wb_data in the same cycle (write-before-read). Operand fetch needs no RW-hazard stall.
- Undefined: the read ports return the pre-write RF contents that cycle. The hazard unit must stall one cycle.
- No other behavioural difference.

Test Plan:
- Reset -> read r0..r15: all 0; retired=0; halted=0. Assert rst mid-write: target register stays 0.
- ALU write: valid, isWb, inst[25:22]=3, alu_res=0x12345678 -> next cycle rs1_addr=3 gives 0x12345678; retired=1.
- Load vs call select:
  - isLd, ldResult=0xDEADBEEF, rd=5 -> r5=0xDEADBEEF.
  - isCall, pc=0x00000100 -> r15=0x00000104.
  - isCall, pc=0xFFFFFFFC -> r15=0.
- Bubble and non-write: valid_MA=0 with isWb=1 -> no write, retired unchanged. Valid with isWb=0 -> no write, retired+1.
- Halt: valid, inst[31:27]=11111, isWb=1 -> no write, retired+1, halted=1. Later valid ALU writes are ignored and the counter is frozen until reset.
- Same-cycle read of the register being written (rd=7, data 0xA5A5A5A5, old value 0):
  - With RW_BYPASS_EN: rs2_data=0xA5A5A5A5.
  - Without: rs2_data=0 that cycle, 0xA5A5A5A5 the next.

Source files
------------

// File: rtl/rw_stage.sv
// -----------------------------------------------------------------------------
// rw_stage : register-write (writeback) stage
//
// Sits directly after the MA/RW pipeline latch. It picks the writeback value,
// owns the architectural register file (NUM_REGS x 32), serves two
// combinational read ports to operand fetch, counts retired instructions and
// detects the halt instruction.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   valid_MA     in   1   latch holds a real instruction (0 = bubble)
//   pc_MA_out    in  32   PC of the retiring instruction
//   ldResult     in  32   load data from MA
//   inst_out_ma  in  32   instruction word (may be X while valid_MA=0)
//   alu_res_MA   in  32   ALU result
//   control_MA   in  22   control word: [1] isLd, [6] isWb, [8] isCall
//   rs1_addr     in   4   read port 1 address
//   rs2_addr     in   4   read port 2 address
//   rs1_data     out 32   read port 1 data (combinational)
//   rs2_data     out 32   read port 2 data (combinational)
//   wb_en        out  1   a register write happens at the next rising edge
//   wb_addr      out  4   destination register
//   wb_data      out 32   value being written
//   retired      out 32   retired-instruction count (wraps)
//   halted       out  1   sticky halt flag
//
// Build option
//   RW_BYPASS_EN : when defined, a read of the register being written this
//                  cycle returns wb_data (write-before-read). When undefined
//                  the read ports show the pre-write contents.
// -----------------------------------------------------------------------------
module rw_stage #(
  parameter int          NUM_REGS    = 16,
  parameter logic [3:0]  RA_INDEX    = 4'd15,
  parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_MA,
  input  logic [31:0] pc_MA_out,
  input  logic [31:0] ldResult,
  input  logic [31:0] inst_out_ma,
  input  logic [31:0] alu_res_MA,
  input  logic [21:0] control_MA,
  input  logic [3:0]  rs1_addr,
  input  logic [3:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retired,
  output logic        halted
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_rf [NUM_REGS];
  logic [31:0] r_retired;

  logic        w_is_ld;
  logic        w_is_wb;
  logic        w_is_call;
  logic        w_is_halt;
  logic        w_wb_en;
  logic [3:0]  w_wb_addr;
  logic [31:0] w_wb_data;
  logic        w_unused;

  assign w_is_ld   = control_MA[1];
  assign w_is_wb   = control_MA[6];
  assign w_is_call = control_MA[8];

  // The opcode compare is qualified by valid_MA so an X instruction word
  // during a bubble cannot leak into the halt decision.
  assign w_is_halt = valid_MA && (inst_out_ma[31:27] == HALT_OPCODE);

  // Bits of the latch that this stage deliberately ignores.
  assign w_unused = ^{control_MA[21:9], control_MA[7], control_MA[5:2],
                      control_MA[0], inst_out_ma[26], inst_out_ma[21:0]};

  // Writeback value: call beats load beats ALU. The +4 wraps naturally.
  always_comb begin
    w_wb_data = alu_res_MA;
    if (w_is_call) begin
      w_wb_data = pc_MA_out + 32'd4;
    end else if (w_is_ld) begin
      w_wb_data = ldResult;
    end
  end

  assign w_wb_addr = w_is_call ? RA_INDEX : inst_out_ma[25:22];

  // State machine: next state and write enable.
  always_comb begin
    w_state_next = r_state;
    w_wb_en      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (valid_MA && w_is_wb && !w_is_halt) begin
          w_wb_en = 1'b1;
        end
        if (w_is_halt) begin
          w_state_next = S_HALTED;
        end
      end
      S_HALTED: begin
        w_state_next = S_HALTED;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Halt instruction itself is counted; nothing counts once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= 32'd0;
    end else if (valid_MA && (r_state == S_RUN)) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // One register per generate slice; reset dominates, so a write that
  // coincides with reset assertion is lost.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rf[gi] <= 32'd0;
        end else if (w_wb_en && (w_wb_addr == 4'(gi))) begin
          r_rf[gi] <= w_wb_data;
        end
      end
    end
  endgenerate

`ifdef RW_BYPASS_EN
  assign rs1_data = (w_wb_en && (rs1_addr == w_wb_addr)) ? w_wb_data : r_rf[rs1_addr];
  assign rs2_data = (w_wb_en && (rs2_addr == w_wb_addr)) ? w_wb_data : r_rf[rs2_addr];
`else
  assign rs1_data = r_rf[rs1_addr];
  assign rs2_data = r_rf[rs2_addr];
`endif

  assign wb_en   = w_wb_en;
  assign wb_addr = w_wb_addr;
  assign wb_data = w_wb_data;
  assign retired = r_retired;
  assign halted  = (r_state == S_HALTED);

endmodule

// File: tb/tb_rw_stage.sv
// -----------------------------------------------------------------------------
// tb_rw_stage : self-checking bench for rw_stage
//
// Directed scenarios plus a randomized run checked against a behavioural
// model (register array, retired count, halt flag) kept in this file.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_rw_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_MA;
  logic [31:0] pc_MA_out;
  logic [31:0] ldResult;
  logic [31:0] inst_out_ma;
  logic [31:0] alu_res_MA;
  logic [21:0] control_MA;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retired;
  logic        halted;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Behavioural model of architectural state
  logic [31:0] m_rf [16];
  logic [31:0] m_retired;
  bit          m_halted;

  always #5 clk = ~clk;

  rw_stage dut (
    .clk        (clk),
    .rst        (rst),
    .valid_MA   (valid_MA),
    .pc_MA_out  (pc_MA_out),
    .ldResult   (ldResult),
    .inst_out_ma(inst_out_ma),
    .alu_res_MA (alu_res_MA),
    .control_MA (control_MA),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .retired    (retired),
    .halted     (halted)
  );

  // ---------------------------------------------------------------- helpers
  function automatic logic [21:0] ctl(bit is_ld, bit is_wb, bit is_call);
    logic [21:0] c;
    c    = 22'h0;
    c[1] = is_ld;
    c[6] = is_wb;
    c[8] = is_call;
    return c;
  endfunction

  // Non-halt instruction with destination rd; opcode 00001, junk elsewhere.
  function automatic logic [31:0] inst_rd(logic [3:0] rd);
    logic [31:0] w;
    w        = $urandom;
    w[31:27] = 5'b00001;
    w[25:22] = rd;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ld,
                       input logic [31:0] inst, input logic [31:0] alu,
                       input logic [21:0] c);
    valid_MA    = v;
    pc_MA_out   = pc;
    ldResult    = ld;
    inst_out_ma = inst;
    alu_res_MA  = alu;
    control_MA  = c;
  endtask

  task automatic bubble();
    drive(1'b0, $urandom, $urandom, 'x, $urandom, ctl(1'b0, 1'b1, 1'b0));
  endtask

  // Expected writeback quantities straight from the stage's rules
  function automatic bit m_is_halt();
    return valid_MA && (inst_out_ma[31:27] == 5'b11111);
  endfunction
  function automatic bit m_wb_en();
    return valid_MA && control_MA[6] && !m_halted && !m_is_halt();
  endfunction
  function automatic logic [31:0] m_wb_val();
    if (control_MA[8]) return pc_MA_out + 32'd4;
    if (control_MA[1]) return ldResult;
    return alu_res_MA;
  endfunction
  function automatic logic [3:0] m_wb_dst();
    return control_MA[8] ? 4'd15 : inst_out_ma[25:22];
  endfunction

  task automatic model_commit();
    if (valid_MA && !m_halted) begin
      m_retired = m_retired + 32'd1;
      if (m_is_halt()) m_halted = 1'b1;
      else if (control_MA[6]) m_rf[m_wb_dst()] = m_wb_val();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_retired = 32'd0;
    m_halted  = 1'b0;
  endtask

  // Advance one rising edge, commit the model, leave 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    bubble();
    rs1_addr = 4'd0;
    rs2_addr = 4'd0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i);
      #1;
      n_total++;
      if (rs1_data !== 32'd0) $display("FAIL reset_rf r%0d: got %h expected 00000000", i, rs1_data);
      else n_pass++;
    end
    n_total++;
    if (retired !== 32'd0) $display("FAIL reset_retired: got %h expected 0", retired);
    else n_pass++;
    n_total++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reset: r0..r15 retired halted checked");

    // Reset asserted while a write to r9 is pending
    drive(1'b1, 32'h0, 32'h0, inst_rd(4'd9), 32'hCAFEF00D, ctl(1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bubble();
    #2;
    rst = 1'b0;
    model_reset();
    rs1_addr = 4'd9;
    #1;
    n_total++;
    if (rs1_data !== 32'd0) $display("FAIL reset_midwrite r9: got %h expected 00000000", rs1_data);
    else n_pass++;
    n_total++;
    if (retired !== 32'd0) $display("FAIL reset_midwrite retired: got %h expected 0", retired);
    else n_pass++;
    tick();
    $display("reset: mid-write reset leaves r9=%h", rs1_data);
  endtask

  task automatic test_alu_write();
    drive(1'b1, 32'h40, 32'h0, inst_rd(4'd3), 32'h12345678, ctl(1'b0, 1'b1, 1'b0));
    @(negedge clk);
    n_total++;
    if (wb_en !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 32'h12345678)
      $display("FAIL alu_wb: got en=%b addr=%0d data=%h expected en=1 addr=3 data=12345678",
               wb_en, wb_addr, wb_data);
    else n_pass++;
    tick();
    bubble();
    rs1_addr = 4'd3;
    #1;
    n_total++;
    if (rs1_data !== 32'h12345678) $display("FAIL alu_read r3: got %h expected 12345678", rs1_data);
    else n_pass++;
    n_total++;
    if (retired !== 32'd1) $display("FAIL alu_retired: got %0d expected 1", retired);
    else n_pass++;
    $display("alu write: r3=%h retired=%0d", rs1_data, retired);
  endtask

  task automatic test_ld_call();
    logic [31:0] pcs  [2];
    logic [31:0] exps [2];
    pcs[0] = 32'h00000100; exps[0] = 32'h00000104;
    pcs[1] = 32'hFFFFFFFC; exps[1] = 32'h00000000;

    drive(1'b1, 32'h80, 32'hDEADBEEF, inst_rd(4'd5), 32'h55555555, ctl(1'b1, 1'b1, 1'b0));
    tick();
    bubble();
    rs1_addr = 4'd5;
    #1;
    n_total++;
    if (rs1_data !== 32'hDEADBEEF) $display("FAIL load r5: got %h expected deadbeef", rs1_data);
    else n_pass++;
    $display("load: r5=%h", rs1_data);

    for (int k = 0; k < 2; k++) begin
      // isLd also set: call must take priority, and rd field points elsewhere
      drive(1'b1, pcs[k], 32'h11111111, inst_rd(4'd6), 32'h22222222, ctl(1'b1, 1'b1, 1'b1));
      @(negedge clk);
      n_total++;
      if (wb_addr !== 4'd15) $display("FAIL call_addr %0d: got %0d expected 15", k, wb_addr);
      else n_pass++;
      tick();
      bubble();
      rs2_addr = 4'd15;
      #1;
      n_total++;
      if (rs2_data !== exps[k]) $display("FAIL call r15 pc=%h: got %h expected %h", pcs[k], rs2_data, exps[k]);
      else n_pass++;
      $display("call: pc=%h r15=%h", pcs[k], rs2_data);
    end
  endtask

  task automatic test_bubble_nowb();
    // retired is 4 here: alu + load + two calls
    drive(1'b0, 32'h0, 32'h0, inst_rd(4'd4), 32'h00000011, ctl(1'b0, 1'b1, 1'b0));
    @(negedge clk);
    n_total++;
    if (wb_en !== 1'b0) $display("FAIL bubble_en: got %b expected 0", wb_en);
    else n_pass++;
    tick();
    rs1_addr = 4'd4;
    #1;
    n_total++;
    if (rs1_data !== 32'd0 || retired !== 32'd4)
      $display("FAIL bubble r4/retired: got %h/%0d expected 00000000/4", rs1_data, retired);
    else n_pass++;
    $display("bubble: r4=%h retired=%0d", rs1_data, retired);

    drive(1'b1, 32'h0, 32'h0, inst_rd(4'd4), 32'h00000022, ctl(1'b0, 1'b0, 1'b0));
    tick();
    bubble();
    #1;
    n_total++;
    if (rs1_data !== 32'd0 || retired !== 32'd5)
      $display("FAIL nowb r4/retired: got %h/%0d expected 00000000/5", rs1_data, retired);
    else n_pass++;
    $display("no-wb: r4=%h retired=%0d", rs1_data, retired);
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
`ifdef RW_BYPASS_EN
    exp_now = 32'hA5A5A5A5;
`else
    exp_now = 32'h00000000;
`endif
    rs2_addr = 4'd7;
    drive(1'b1, 32'h0, 32'h0, inst_rd(4'd7), 32'hA5A5A5A5, ctl(1'b0, 1'b1, 1'b0));
    @(negedge clk);
    n_total++;
    if (rs2_data !== exp_now) $display("FAIL same_cycle r7: got %h expected %h", rs2_data, exp_now);
    else n_pass++;
    tick();
    bubble();
    #1;
    n_total++;
    if (rs2_data !== 32'hA5A5A5A5) $display("FAIL next_cycle r7: got %h expected a5a5a5a5", rs2_data);
    else n_pass++;
    $display("same-cycle read r7: then=%h now=%h", exp_now, rs2_data);
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    int unsigned errs;
    for (int n = 0; n < 300; n++) begin
      errs = 0;
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, inst_rd(4'($urandom_range(0, 15))),
            $urandom, ctl($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) == 0));
      control_MA[21:9] = 13'($urandom);  // ignored bits
      rs1_addr = 4'($urandom_range(0, 15));
      rs2_addr = 4'($urandom_range(0, 15));
      @(negedge clk);
      e1 = m_rf[rs1_addr];
      e2 = m_rf[rs2_addr];
`ifdef RW_BYPASS_EN
      if (m_wb_en() && rs1_addr == m_wb_dst()) e1 = m_wb_val();
      if (m_wb_en() && rs2_addr == m_wb_dst()) e2 = m_wb_val();
`endif
      n_total++;
      if (wb_en !== m_wb_en()) begin
        $display("FAIL rand_wb_en #%0d: got %b expected %b", n, wb_en, m_wb_en());
        errs++;
      end else n_pass++;
      if (m_wb_en()) begin
        n_total++;
        if (wb_addr !== m_wb_dst() || wb_data !== m_wb_val()) begin
          $display("FAIL rand_wb #%0d: got %0d/%h expected %0d/%h", n, wb_addr, wb_data,
                   m_wb_dst(), m_wb_val());
          errs++;
        end else n_pass++;
      end
      n_total++;
      if (rs1_data !== e1 || rs2_data !== e2) begin
        $display("FAIL rand_read #%0d: got r%0d=%h r%0d=%h expected %h %h", n, rs1_addr,
                 rs1_data, rs2_addr, rs2_data, e1, e2);
        errs++;
      end else n_pass++;
      tick();
      n_total++;
      if (retired !== m_retired || halted !== 1'b0) begin
        $display("FAIL rand_retired #%0d: got %0d/%b expected %0d/0", n, retired, halted, m_retired);
        errs++;
      end else n_pass++;
      $display("rand #%0d: v=%b en=%b rd=%0d data=%h retired=%0d errs=%0d", n, valid_MA,
               wb_en, wb_addr, wb_data, retired, errs);
    end
  endtask

  task automatic test_halt();
    logic [31:0] inst;
    logic [31:0] ret_before;
    logic [31:0] r2_before;
    bubble();
    rs1_addr = 4'd2;
    #1;
    ret_before = m_retired;
    r2_before  = m_rf[2];
    inst        = inst_rd(4'd2);
    inst[31:27] = 5'b11111;
    drive(1'b1, 32'h0, 32'h0, inst, ~r2_before, ctl(1'b0, 1'b1, 1'b0));
    @(negedge clk);
    n_total++;
    if (wb_en !== 1'b0) $display("FAIL halt_wb_en: got %b expected 0", wb_en);
    else n_pass++;
    tick();
    bubble();
    #1;
    n_total++;
    if (halted !== 1'b1 || retired !== ret_before + 32'd1 || rs1_data !== r2_before)
      $display("FAIL halt_state: got halted=%b retired=%0d r2=%h expected 1/%0d/%h",
               halted, retired, rs1_data, ret_before + 32'd1, r2_before);
    else n_pass++;
    $display("halt: halted=%b retired=%0d", halted, retired);

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h0, 32'h0, inst_rd(4'd2), $urandom | 32'h1, ctl(1'b0, 1'b1, 1'b0));
      @(negedge clk);
      n_total++;
      if (wb_en !== 1'b0) $display("FAIL halted_wb_en %0d: got %b expected 0", k, wb_en);
      else n_pass++;
      tick();
    end
    bubble();
    #1;
    n_total++;
    if (halted !== 1'b1 || retired !== ret_before + 32'd1 || rs1_data !== r2_before)
      $display("FAIL halted_frozen: got halted=%b retired=%0d r2=%h expected 1/%0d/%h",
               halted, retired, rs1_data, ret_before + 32'd1, r2_before);
    else n_pass++;
    $display("halted: writes ignored, retired=%0d", retired);

    rst = 1'b1;
    #2;
    n_total++;
    if (halted !== 1'b0 || retired !== 32'd0)
      $display("FAIL halt_reset: got halted=%b retired=%0d expected 0/0", halted, retired);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("halt cleared by reset");
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_ld_call();
    test_bubble_nowb();
    test_same_cycle();
    test_random();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
